// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: queues parallel words in a small FIFO and
// shifts them out MSB-first, one bit per clock, back-to-back with no gap.
module serial_pattern_tx #(
  parameter int   DATA_W   = 8,
  parameter int   DEPTH    = 4,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     w_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;

  logic [0:0]        state;
  logic [0:0]        state_n;
  logic [CNT_W-1:0]  bitcnt;
  logic [CNT_W-1:0]  bitcnt_n;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] sreg_n;
  logic              w_n;
  logic              busy_n;
  logic              done_n;

  logic [DATA_W-1:0] head;
  logic              wr_acc;
  logic              pop;

  assign head    = mem[rd_ptr];
  assign full_o  = (count == LVL_W'(DEPTH));
  assign level_o = count;

  // A full FIFO drops the write even if a pop frees a slot at the same edge.
  assign wr_acc = wr_en_i & ~full_o;

  // Pop when idle, or when the LSB of the current word is on the line, so
  // the next word follows with no gap cycle.
  assign pop = (count != '0) & ((state == ST_IDLE) | (bitcnt == '0));

  // Next-state and next-output logic for the shifter.
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    sreg_n   = sreg;
    w_n      = w_o;
    busy_n   = busy_o;
    if (pop) begin
      state_n  = ST_SHIFT;
      sreg_n   = head;
      w_n      = head[DATA_W-1];
      busy_n   = 1'b1;
      bitcnt_n = CNT_W'(DATA_W - 1);
    end else if (state == ST_SHIFT) begin
      if (bitcnt != '0) begin
        sreg_n   = sreg << 1;
        w_n      = sreg[DATA_W-2];
        bitcnt_n = bitcnt - CNT_W'(1);
      end else begin
        state_n = ST_IDLE;
        w_n     = IDLE_LVL;
        busy_n  = 1'b0;
      end
    end
    // Registered form of busy & (bitcnt == 0) so done_o cannot glitch.
    done_n = busy_n & (bitcnt_n == '0);
  end

  // Control registers: FIFO bookkeeping, FSM and serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= ST_IDLE;
      bitcnt <= '0;
      w_o    <= IDLE_LVL;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_acc, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
      state  <= state_n;
      bitcnt <= bitcnt_n;
      w_o    <= w_n;
      busy_o <= busy_n;
      done_o <= done_n;
    end
  end

  // Data registers: FIFO storage and shift register carry no reset.
  always_ff @(posedge clk) begin
    sreg <= sreg_n;
    if (wr_acc) mem[wr_ptr] <= wr_data_i;
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx (DATA_W=8, DEPTH=4, IDLE_LVL=0).
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en_i;
  logic [7:0] wr_data_i;
  logic       full_o;
  logic [2:0] level_o;
  logic       w_o;
  logic       busy_o;
  logic       done_o;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: queued words plus the bits of the word on the line
  // (element 0 is the bit currently driven on w_o).
  logic [7:0] mq[$];
  bit         bq[$];

  serial_pattern_tx #(.DATA_W(8), .DEPTH(4), .IDLE_LVL(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_i),
    .wr_data_i (wr_data_i),
    .full_o    (full_o),
    .level_o   (level_o),
    .w_o       (w_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    mq.delete();
    bq.delete();
  endfunction

  function automatic void model_edge(bit wr, logic [7:0] d);
    bit         acc;
    logic [7:0] w;
    acc = wr && (mq.size() < 4);
    if (bq.size() > 0) void'(bq.pop_front());
    if (bq.size() == 0 && mq.size() > 0) begin
      w = mq.pop_front();
      for (int i = 7; i >= 0; i--) bq.push_back(w[i]);
    end
    if (acc) mq.push_back(d);
  endfunction

  // {w, busy, done, full, level}
  function automatic logic [6:0] exp_vec();
    logic w;
    w = (bq.size() > 0) ? logic'(bq[0]) : 1'b0;
    return {w, logic'(bq.size() > 0), logic'(bq.size() == 1),
            logic'(mq.size() == 4), 3'(mq.size())};
  endfunction

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(wr_en_i, wr_data_i);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst       = 1'b1;
      wr_en_i   = i[0] ? 1'b0 : 1'b1;
      wr_data_i = 8'($urandom);
      cycle();
      n_chk++;
      if ({w_o, busy_o, done_o, full_o, level_o} !== 7'b0000_000)
        $display("FAIL reset[%0d] got=%b exp=%b", i,
                 {w_o, busy_o, done_o, full_o, level_o}, 7'b0);
      else n_pass++;
    end
    rst     = 1'b0;
    wr_en_i = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] pat;
    pat = 8'hB5;
    wr_en_i = 1'b1; wr_data_i = pat;
    cycle();
    wr_en_i = 1'b0;
    n_chk++;
    if (busy_o !== 1'b0 || level_o !== 3'd1)
      $display("FAIL single_latency got busy=%b lvl=%0d exp busy=0 lvl=1", busy_o, level_o);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_chk++;
      if (w_o !== pat[7-i] || busy_o !== 1'b1 || done_o !== (i == 7))
        $display("FAIL single_bit[%0d] got w=%b busy=%b done=%b exp w=%b busy=1 done=%b",
                 i, w_o, busy_o, done_o, pat[7-i], (i == 7));
      else n_pass++;
    end
    cycle();
    n_chk++;
    if (w_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0)
      $display("FAIL single_after got w=%b busy=%b done=%b exp 0 0 0", w_o, busy_o, done_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    int          dones;
    bits  = 16'b10100000_00001111;
    dones = 0;
    wr_en_i = 1'b1; wr_data_i = 8'hA0;
    cycle();
    wr_data_i = 8'h0F;
    cycle();
    wr_en_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) cycle();
      if (done_o === 1'b1) dones++;
      n_chk++;
      if (w_o !== bits[15-i] || busy_o !== 1'b1 || done_o !== (i == 7 || i == 15))
        $display("FAIL b2b_bit[%0d] got w=%b busy=%b done=%b exp w=%b busy=1 done=%b",
                 i, w_o, busy_o, done_o, bits[15-i], (i == 7 || i == 15));
      else n_pass++;
    end
    cycle();
    n_chk++;
    if (dones !== 2 || busy_o !== 1'b0)
      $display("FAIL b2b_end got dones=%0d busy=%b exp dones=2 busy=0", dones, busy_o);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] words[7];
    bit         rx[$];
    bit         saw_full;
    logic [6:0] e;
    saw_full = 1'b0;
    for (int i = 0; i < 7; i++) words[i] = 8'($urandom);
    for (int i = 0; i < 7; i++) begin
      wr_en_i = 1'b1; wr_data_i = words[i];
      cycle();
      if (busy_o) rx.push_back(w_o);
      if (full_o) saw_full = 1'b1;
      e = exp_vec();
      n_chk++;
      if ({w_o, busy_o, done_o, full_o, level_o} !== e)
        $display("FAIL overflow_wr[%0d] got=%b exp=%b", i, {w_o, busy_o, done_o, full_o, level_o}, e);
      else n_pass++;
    end
    wr_en_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (busy_o) rx.push_back(w_o);
      e = exp_vec();
      n_chk++;
      if ({w_o, busy_o, done_o, full_o, level_o} !== e)
        $display("FAIL overflow_drain[%0d] got=%b exp=%b", i, {w_o, busy_o, done_o, full_o, level_o}, e);
      else n_pass++;
    end
    // Only the first five writes fit (one shifting, four queued).
    n_chk++;
    if (!saw_full || rx.size() != 40)
      $display("FAIL overflow_count got full_seen=%b bits=%0d exp full_seen=1 bits=40", saw_full, rx.size());
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      logic [7:0] got;
      got = '0;
      for (int b = 0; b < 8; b++)
        if (rx.size() > k*8 + b) got = {got[6:0], logic'(rx[k*8 + b])};
      n_chk++;
      if (got !== words[k])
        $display("FAIL overflow_word[%0d] got=%h exp=%h", k, got, words[k]);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] pat;
    pat = 8'h81;
    wr_en_i = 1'b1; wr_data_i = 8'hFF; cycle();
    wr_data_i = 8'h3C; cycle();
    wr_data_i = 8'hC3; cycle();
    wr_en_i = 1'b0;
    cycle();
    cycle();
    n_chk++;
    if (w_o !== 1'b1 || level_o !== 3'd2)
      $display("FAIL midrst_pre got w=%b lvl=%0d exp w=1 lvl=2", w_o, level_o);
    else n_pass++;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_chk++;
    if (w_o !== 1'b0 || level_o !== 3'd0 || busy_o !== 1'b0)
      $display("FAIL midrst_post got w=%b lvl=%0d busy=%b exp 0 0 0", w_o, level_o, busy_o);
    else n_pass++;
    cycle();
    wr_en_i = 1'b1; wr_data_i = pat;
    cycle();
    wr_en_i = 1'b0;
    n_chk++;
    if (busy_o !== 1'b0 || w_o !== 1'b0)
      $display("FAIL midrst_latency got busy=%b w=%b exp busy=0 w=0", busy_o, w_o);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_chk++;
      if (w_o !== pat[7-i] || busy_o !== 1'b1)
        $display("FAIL midrst_bit[%0d] got w=%b busy=%b exp w=%b busy=1", i, w_o, busy_o, pat[7-i]);
      else n_pass++;
    end
    cycle();
    n_chk++;
    if (busy_o !== 1'b0 || w_o !== 1'b0)
      $display("FAIL midrst_after got busy=%b w=%b exp 0 0", busy_o, w_o);
    else n_pass++;
  endtask

  task automatic test_full_collision();
    logic [7:0] w1;
    logic [6:0] e;
    bit         hit;
    hit = 1'b0;
    w1  = 8'($urandom);
    wr_en_i = 1'b1; wr_data_i = 8'($urandom); cycle();
    wr_data_i = w1;              cycle();
    wr_data_i = 8'($urandom);    cycle();
    wr_data_i = 8'($urandom);    cycle();
    wr_en_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_o === 1'b1) begin
        hit = 1'b1;
        break;
      end
      cycle();
    end
    n_chk++;
    if (!hit || level_o !== 3'd3)
      $display("FAIL collide_setup got done_seen=%b lvl=%0d exp done_seen=1 lvl=3", hit, level_o);
    else n_pass++;
    wr_en_i = 1'b1; wr_data_i = 8'($urandom);
    cycle();
    wr_en_i = 1'b0;
    n_chk++;
    if (level_o !== 3'd3 || busy_o !== 1'b1 || w_o !== w1[7] || done_o !== 1'b0)
      $display("FAIL collide_edge got lvl=%0d busy=%b w=%b done=%b exp lvl=3 busy=1 w=%b done=0",
               level_o, busy_o, w_o, done_o, w1[7]);
    else n_pass++;
    for (int i = 0; i < 36; i++) begin
      cycle();
      e = exp_vec();
      n_chk++;
      if ({w_o, busy_o, done_o, full_o, level_o} !== e)
        $display("FAIL collide_drain[%0d] got=%b exp=%b", i, {w_o, busy_o, done_o, full_o, level_o}, e);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [6:0] e;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      wr_en_i   = ($urandom_range(0, 3) == 0);
      wr_data_i = 8'($urandom);
      cycle();
      e = exp_vec();
      n_chk++;
      if ({w_o, busy_o, done_o, full_o, level_o} !== e)
        $display("FAIL random[%0d] got=%b exp=%b", i, {w_o, busy_o, done_o, full_o, level_o}, e);
      else n_pass++;
    end
    rst     = 1'b0;
    wr_en_i = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    wr_en_i   = 1'b0;
    wr_data_i = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    test_full_collision();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
